control_sequencer: RTL and testbench

- Hard-wired control unit that sits directly upstream of the datapath.
- Steps through the fetch cycles T0–T2 and an opcode-dependent execute sequence T3–T7.
- Drives every datapath strobe from the registered state, so the datapath no longer needs bench-driven control.
- Reads the IR opcode and CON FF back from the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 70 +++++++
 rtl/control_sequencer.sv | 150 +++++++++++++++
 tb/tb_control_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding, opcode constants and opcode-class decode for control_sequencer.
package cpu_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int OP_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_AND  = 5'd5;
  localparam logic [OP_W-1:0] OP_OR   = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd9;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BR   = 5'd19;
  localparam logic [OP_W-1:0] OP_JR   = 5'd20;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd24;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd25;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST,
    CLS_BR, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } op_class_e;

  // Undefined opcodes fall into CLS_NOP so they retire after an empty T3.
  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:   return CLS_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:  return CLS_ALU_I;
      OP_NEG, OP_NOT:            return CLS_UNARY;
      OP_DIV, OP_MUL:            return CLS_MULDIV;
      OP_LD:                     return CLS_LD;
      OP_LDI:                    return CLS_LDI;
      OP_ST:                     return CLS_ST;
      OP_BR:                     return CLS_BR;
      OP_JR:                     return CLS_JR;
      OP_MFHI:                   return CLS_MFHI;
      OP_MFLO:                   return CLS_MFLO;
      OP_HALT:                   return CLS_HALT;
      default:                   return CLS_NOP;
    endcase
  endfunction

  function automatic logic [OP_W-1:0] alu_imm_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch T0-T2, opcode-dependent execute T3-T7, HALT.
// Build option CTRL_MEM_WAIT_EN stretches memory states until mem_ready is sampled high.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  input  logic [OP_W-1:0]    ir_op,
  input  logic               con_ff,
  input  logic               mem_ready,
  output logic Gra, Grb, Grc, Rin, Rout, BAout,
  output logic HIout, HIin, LOout, LOin, Zhighout, Zlowout, Zin, Yin, Cout,
  output logic MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, CONin,
  output logic read, write,
  output logic [OP_W-1:0]    opcode,
  output logic               run,
  output logic [STATE_W-1:0] o_dbg_state
);

  state_e    r_state;
  state_e    w_next;
  op_class_e w_cls;

  assign w_cls       = op_class(ir_op);
  assign o_dbg_state = r_state;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0:  w_next = S_T1;
      S_T1:  w_next = S_T2;
      S_T2:  w_next = S_T3;
      S_T3: begin
        case (w_cls)
          CLS_HALT:                            w_next = S_HALT;
          CLS_JR, CLS_MFHI, CLS_MFLO, CLS_NOP: w_next = S_T0;
          default:                             w_next = S_T4;
        endcase
      end
      S_T4:  w_next = (w_cls == CLS_UNARY) ? S_T0 : S_T5;
      S_T5: begin
        case (w_cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LDI: w_next = S_T0;
          default:                       w_next = S_T6;
        endcase
      end
      S_T6:  w_next = (w_cls == CLS_LD || w_cls == CLS_ST) ? S_T7 : S_T0;
      S_T7:  w_next = S_T0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
`ifdef CTRL_MEM_WAIT_EN
    // Any state strobing memory stays put until the memory reports done.
    if ((read || write) && !mem_ready) w_next = r_state;
`endif
  end

`ifndef CTRL_MEM_WAIT_EN
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
`endif

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {HIout, HIin, LOout, LOin, Zhighout, Zlowout, Zin, Yin, Cout} = '0;
    {MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, CONin} = '0;
    {read, write} = '0;
    opcode = OP_NOP;
    run    = 1'b1;
    case (r_state)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        case (w_cls)
          CLS_ALU_R, CLS_MULDIV, CLS_ALU_I: {Grb, Rout, Yin} = '1;
          CLS_UNARY: begin
            {Grb, Rout, Zin} = '1;
            opcode = ir_op;
          end
          CLS_LD, CLS_LDI, CLS_ST: {Grb, BAout, Yin} = '1;
          CLS_BR:   {Gra, Rout, CONin} = '1;
          CLS_JR:   {Gra, Rout, PCin} = '1;
          CLS_MFHI: {HIout, Gra, Rin} = '1;
          CLS_MFLO: {LOout, Gra, Rin} = '1;
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          CLS_ALU_R, CLS_MULDIV: begin
            {Grc, Rout, Zin} = '1;
            opcode = ir_op;
          end
          CLS_ALU_I: begin
            {Cout, Zin} = '1;
            opcode = alu_imm_op(ir_op);
          end
          CLS_UNARY: {Zlowout, Gra, Rin} = '1;
          CLS_LD, CLS_LDI, CLS_ST: begin
            {Cout, Zin} = '1;
            opcode = OP_ADD;
          end
          CLS_BR: {PCout, Yin} = '1;
          default: ;
        endcase
      end
      S_T5: begin
        case (w_cls)
          CLS_ALU_R, CLS_ALU_I, CLS_LDI: {Zlowout, Gra, Rin} = '1;
          CLS_MULDIV:                    {Zlowout, LOin} = '1;
          CLS_LD, CLS_ST:                {Zlowout, MARin} = '1;
          CLS_BR: begin
            {Cout, Zin} = '1;
            opcode = OP_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          CLS_MULDIV: {Zhighout, HIin} = '1;
          CLS_LD:     {read, MDRin} = '1;
          CLS_ST:     {Gra, Rout, MDRin} = '1;
          CLS_BR: begin
            Zlowout = 1'b1;
            PCin    = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_cls)
          CLS_LD:  {MDRout, Gra, Rin} = '1;
          CLS_ST:  write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random opcode streams
// checked cycle by cycle against a table-driven instruction model.
module tb_control_sequencer;

  logic       clock, clear, con_ff, mem_ready;
  logic [4:0] ir_op;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic HIout, HIin, LOout, LOin, Zhighout, Zlowout, Zin, Yin, Cout;
  logic MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, CONin;
  logic read, write, run;
  logic [4:0] opcode;
  logic [3:0] dbg_state;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir_op(ir_op), .con_ff(con_ff), .mem_ready(mem_ready),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .Zin(Zin), .Yin(Yin), .Cout(Cout),
    .MDRout(MDRout), .MDRin(MDRin), .MARin(MARin), .PCout(PCout), .PCin(PCin),
    .IRin(IRin), .IncPC(IncPC), .CONin(CONin), .read(read), .write(write),
    .opcode(opcode), .run(run), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed word layout: {run, opcode, 25 strobes}
  localparam logic [24:0] M_GRA = 25'h1 << 24, M_GRB = 25'h1 << 23, M_GRC = 25'h1 << 22;
  localparam logic [24:0] M_RIN = 25'h1 << 21, M_ROUT = 25'h1 << 20, M_BAOUT = 25'h1 << 19;
  localparam logic [24:0] M_HIOUT = 25'h1 << 18, M_HIIN = 25'h1 << 17, M_LOOUT = 25'h1 << 16;
  localparam logic [24:0] M_LOIN = 25'h1 << 15, M_ZHIOUT = 25'h1 << 14, M_ZLOOUT = 25'h1 << 13;
  localparam logic [24:0] M_ZIN = 25'h1 << 12, M_YIN = 25'h1 << 11, M_COUT = 25'h1 << 10;
  localparam logic [24:0] M_MDROUT = 25'h1 << 9, M_MDRIN = 25'h1 << 8, M_MARIN = 25'h1 << 7;
  localparam logic [24:0] M_PCOUT = 25'h1 << 6, M_PCIN = 25'h1 << 5, M_IRIN = 25'h1 << 4;
  localparam logic [24:0] M_INCPC = 25'h1 << 3, M_CONIN = 25'h1 << 2, M_READ = 25'h1 << 1;
  localparam logic [24:0] M_WRITE = 25'h1;
  localparam logic [4:0]  NOP = 5'b11010;

  int n_checks = 0;
  int n_errors = 0;
  logic [30:0] base_q[$];
  logic [30:0] exp_q[$];
  logic [30:0] obs_q[$];
  bit rand_mr = 1'b0;

  function automatic logic [30:0] w(input logic [24:0] s, input logic [4:0] op = NOP,
                                    input logic r = 1'b1);
    return {r, op, s};
  endfunction

  function automatic logic [30:0] observe();
    return {run, opcode, Gra, Grb, Grc, Rin, Rout, BAout, HIout, HIin, LOout, LOin,
            Zhighout, Zlowout, Zin, Yin, Cout, MDRout, MDRin, MARin, PCout, PCin,
            IRin, IncPC, CONin, read, write};
  endfunction

  // Reference model: the full per-cycle control word list for one instruction.
  function automatic void build_base(input logic [4:0] op, input logic con);
    base_q.delete();
    base_q.push_back(w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
    base_q.push_back(w(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN));
    base_q.push_back(w(M_MDROUT | M_IRIN));
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        base_q.push_back(w(M_GRB | M_ROUT | M_YIN));
        base_q.push_back(w(M_GRC | M_ROUT | M_ZIN, op));
        base_q.push_back(w(M_ZLOOUT | M_GRA | M_RIN));
      end
      5'd15, 5'd16: begin
        base_q.push_back(w(M_GRB | M_ROUT | M_YIN));
        base_q.push_back(w(M_GRC | M_ROUT | M_ZIN, op));
        base_q.push_back(w(M_ZLOOUT | M_LOIN));
        base_q.push_back(w(M_ZHIOUT | M_HIIN));
      end
      5'd12, 5'd13, 5'd14: begin
        base_q.push_back(w(M_GRB | M_ROUT | M_YIN));
        base_q.push_back(w(M_COUT | M_ZIN, (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6));
        base_q.push_back(w(M_ZLOOUT | M_GRA | M_RIN));
      end
      5'd17, 5'd18: begin
        base_q.push_back(w(M_GRB | M_ROUT | M_ZIN, op));
        base_q.push_back(w(M_ZLOOUT | M_GRA | M_RIN));
      end
      5'd0, 5'd1, 5'd2: begin
        base_q.push_back(w(M_GRB | M_BAOUT | M_YIN));
        base_q.push_back(w(M_COUT | M_ZIN, 5'd3));
        if (op == 5'd1) begin
          base_q.push_back(w(M_ZLOOUT | M_GRA | M_RIN));
        end else begin
          base_q.push_back(w(M_ZLOOUT | M_MARIN));
          if (op == 5'd0) begin
            base_q.push_back(w(M_READ | M_MDRIN));
            base_q.push_back(w(M_MDROUT | M_GRA | M_RIN));
          end else begin
            base_q.push_back(w(M_GRA | M_ROUT | M_MDRIN));
            base_q.push_back(w(M_WRITE));
          end
        end
      end
      5'd19: begin
        base_q.push_back(w(M_GRA | M_ROUT | M_CONIN));
        base_q.push_back(w(M_PCOUT | M_YIN));
        base_q.push_back(w(M_COUT | M_ZIN, 5'd3));
        base_q.push_back(w(M_ZLOOUT | (con ? M_PCIN : 25'h0)));
      end
      5'd20: base_q.push_back(w(M_GRA | M_ROUT | M_PCIN));
      5'd24: base_q.push_back(w(M_HIOUT | M_GRA | M_RIN));
      5'd25: base_q.push_back(w(M_LOOUT | M_GRA | M_RIN));
      5'd27: begin
        base_q.push_back(w(25'h0));
        for (int i = 0; i < 10; i++) base_q.push_back(w(25'h0, NOP, 1'b0));
      end
      default: base_q.push_back(w(25'h0));
    endcase
  endfunction

  // driver tasks
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Runs one instruction starting in T0; records observed and expected words per cycle.
  task automatic run_op(input logic [4:0] op, input logic con);
    logic [30:0] cur;
    logic hold;
    build_base(op, con);
    ir_op  = op;
    con_ff = con;
    exp_q.delete();
    obs_q.delete();
    while (base_q.size() > 0) begin
      cur = base_q[0];
      obs_q.push_back(observe());
      exp_q.push_back(cur);
      mem_ready = rand_mr ? ($urandom_range(0, 2) != 0) : 1'b1;
      hold = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
      hold = (cur[1] | cur[0]) & ~mem_ready;
`endif
      if (!hold) void'(base_q.pop_front());
      step();
    end
  endtask

  // tests
  task automatic test_reset();
    clear = 1'b0; ir_op = 5'd0; con_ff = 1'b0; mem_ready = 1'b1;
    repeat (2) begin
      step();
      n_checks++;
      if (observe() !== w(25'h0)) begin
        n_errors++;
        $display("FAIL reset_hold: got %h expected %h", observe(), w(25'h0));
      end
    end
    clear = 1'b1;
    step();
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL reset_t0: got %h expected %h", observe(), w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
    end
  endtask

  task automatic test_ld();
    run_op(5'd0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL ld cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_q[4][29:25] !== 5'd3 || obs_q[4][10] !== 1'b1) begin
      n_errors++;
      $display("FAIL ld_t4_add: got opcode %b cout %b expected 00011 1", obs_q[4][29:25], obs_q[4][10]);
    end
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL ld_return_t0: got %h", observe());
    end
  endtask

  task automatic test_mul();
    run_op(5'd16, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL mul cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL mul_return_t0: got %h", observe());
    end
  endtask

  task automatic test_br();
    for (int c = 1; c >= 0; c--) begin
      run_op(5'd19, c[0]);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL br con=%0d cycle %0d: got %h expected %h", c, i, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (obs_q[6][5] !== c[0]) begin
        n_errors++;
        $display("FAIL br_t6_pcin con=%0d: got %b expected %b", c, obs_q[6][5], c[0]);
      end
    end
  endtask

  task automatic test_halt();
    run_op(5'd27, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL halt cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear = 1'b0;
    #1;
    n_checks++;
    if (observe() !== w(25'h0)) begin
      n_errors++;
      $display("FAIL halt_clear: got %h expected %h", observe(), w(25'h0));
    end
    step();
    clear = 1'b1;
    step();
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL halt_restart_t0: got %h", observe());
    end
  endtask

  task automatic test_mid_clear();
    ir_op = 5'd0;
    repeat (4) step();
    clear = 1'b0;
    #1;
    n_checks++;
    if (observe() !== w(25'h0)) begin
      n_errors++;
      $display("FAIL mid_clear: got %h expected %h", observe(), w(25'h0));
    end
    step();
    clear = 1'b1;
    step();
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL mid_clear_t0: got %h", observe());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    rand_mr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = NOP;
      run_op(op, 1'($urandom_range(0, 1)));
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL rand op=%b cycle %0d: got %h expected %h", op, i, obs_q[i], exp_q[i]);
        end
      end
    end
    rand_mr = 1'b0;
    mem_ready = 1'b1;
  endtask

`ifdef CTRL_MEM_WAIT_EN
  task automatic test_mem_wait();
    ir_op = NOP;
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (observe() !== w(M_ZLOOUT | M_PCIN | M_READ | M_MDRIN)) begin
        n_errors++;
        $display("FAIL mem_wait_t1 %0d: got %h", i, observe());
      end
      if (i == 2) mem_ready = 1'b1;
      step();
    end
    n_checks++;
    if (observe() !== w(M_MDROUT | M_IRIN)) begin
      n_errors++;
      $display("FAIL mem_wait_t2: got %h", observe());
    end
    step();
    step();
    mem_ready = 1'b0;
    step();
    clear = 1'b0;
    #1;
    n_checks++;
    if (observe() !== w(25'h0)) begin
      n_errors++;
      $display("FAIL mem_wait_clear: got %h", observe());
    end
    step();
    clear = 1'b1;
    mem_ready = 1'b1;
    step();
    n_checks++;
    if (observe() !== w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
      n_errors++;
      $display("FAIL mem_wait_t0: got %h", observe());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ld();
    test_mul();
    test_br();
    test_halt();
    test_mid_clear();
    test_back_to_back();
`ifdef CTRL_MEM_WAIT_EN
    test_mem_wait();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
